// File: rtl/data_sram_resp.sv
// Data SRAM responder: word RAM plus an MMIO block (LED, SCRATCH, optional TIMER) with 1-cycle reads.
// Optional TIMER register enabled by defining DATA_SRAM_RESP_TIMER_EN.
module data_sram_resp #(
    parameter int unsigned RAM_AW    = 12,
    parameter logic [15:0] MMIO_BASE = 16'hbfaf
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_we,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic [15:0] led
);

    localparam int unsigned RAM_WORDS = 2 ** RAM_AW;
    localparam int unsigned OFF_W     = 14;

    // MMIO word offsets (byte offset >> 2)
    localparam logic [OFF_W-1:0] LED_WORD     = 14'h3c00;
    localparam logic [OFF_W-1:0] SCRATCH_WORD = 14'h3c08;
    localparam logic [OFF_W-1:0] TIMER_WORD   = 14'h3800;

    logic [31:0]        ram [RAM_WORDS];
    logic [31:0]        scratch;
    logic               is_mmio_c;
    logic [OFF_W-1:0]   mmio_word_c;
    logic [RAM_AW-1:0]  ram_idx_c;
    logic               rd_req_c;
    logic               wr_req_c;
    logic               ram_we_c;
    logic [31:0]        rd_val_c;
    logic               unused_addr_lsb;

    assign unused_addr_lsb = ^data_sram_addr[1:0];

    // Merge write data into an existing word by byte enable.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

    // Request decode
    always_comb begin
        is_mmio_c   = (data_sram_addr[31:16] == MMIO_BASE);
        mmio_word_c = data_sram_addr[15:2];
        ram_idx_c   = data_sram_addr[RAM_AW+1:2];
        rd_req_c    = data_sram_en && (data_sram_we == 4'b0000);
        wr_req_c    = data_sram_en && (data_sram_we != 4'b0000);
        ram_we_c    = wr_req_c && !is_mmio_c && !reset;
    end

`ifdef DATA_SRAM_RESP_TIMER_EN
    logic [31:0] timer;

    // Free-running counter; a write wins over the increment for that edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer <= 32'h0;
        end else if (wr_req_c && is_mmio_c && (mmio_word_c == TIMER_WORD)) begin
            timer <= merge_bytes(timer, data_sram_wdata, data_sram_we);
        end else begin
            timer <= timer + 32'd1;
        end
    end
`endif

    // Read mux; unmapped MMIO offsets read as zero
    always_comb begin
        rd_val_c = 32'h0;
        if (is_mmio_c) begin
            case (mmio_word_c)
                LED_WORD:     rd_val_c = {16'h0, led};
                SCRATCH_WORD: rd_val_c = scratch;
`ifdef DATA_SRAM_RESP_TIMER_EN
                TIMER_WORD:   rd_val_c = timer;
`endif
                default:      rd_val_c = 32'h0;
            endcase
        end else begin
            rd_val_c = ram[ram_idx_c];
        end
    end

    // RAM has no reset so its contents survive a reset pulse
    always_ff @(posedge clk) begin
        if (ram_we_c) begin
            for (int i = 0; i < 4; i++) begin
                if (data_sram_we[i]) ram[ram_idx_c][8*i +: 8] <= data_sram_wdata[8*i +: 8];
            end
        end
    end

    // MMIO registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led     <= 16'h0;
            scratch <= 32'h0;
        end else if (wr_req_c && is_mmio_c) begin
            if (mmio_word_c == LED_WORD) begin
                led <= 16'(merge_bytes({16'h0, led}, data_sram_wdata, data_sram_we));
            end
            if (mmio_word_c == SCRATCH_WORD) begin
                scratch <= merge_bytes(scratch, data_sram_wdata, data_sram_we);
            end
        end
    end

    // Read data captured on the request edge, held otherwise
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_sram_rdata <= 32'h0;
        end else if (rd_req_c) begin
            data_sram_rdata <= rd_val_c;
        end
    end

endmodule

// File: tb/tb_data_sram_resp.sv
// Directed self-checking bench for data_sram_resp: RAM, byte lanes, MMIO, timer, reset.
module tb_data_sram_resp;

    logic        clk;
    logic        reset;
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [15:0] led;

    int checks;
    int errors;

    data_sram_resp dut (
        .clk             (clk),
        .reset           (reset),
        .data_sram_en    (en),
        .data_sram_we    (we),
        .data_sram_addr  (addr),
        .data_sram_wdata (wdata),
        .data_sram_rdata (rdata),
        .led             (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one request at the falling edge, return 1 time unit after the rising edge.
    task automatic drive(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        en    = e;
        we    = w;
        addr  = a;
        wdata = d;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if (rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata: got %h expected %h", rdata, 32'h0);
        end
        checks++;
        if (led !== 16'h0) begin
            errors++;
            $display("FAIL reset_led: got %h expected %h", led, 16'h0);
        end
        // A write while reset is held must be blocked
        drive(1'b1, 4'hf, 32'hbfaff000, 32'h0000ffff);
        checks++;
        if (led !== 16'h0) begin
            errors++;
            $display("FAIL reset_blocks_write: got %h expected %h", led, 16'h0);
        end
        @(negedge clk);
        en    = 1'b0;
        we    = 4'h0;
        reset = 1'b0;
    endtask

    task automatic test_ram_write_read;
        drive(1'b1, 4'hf, 32'h00000010, 32'h11223344);
        checks++;
        if (rdata !== 32'h0) begin
            errors++;
            $display("FAIL write_holds_rdata: got %h expected %h", rdata, 32'h0);
        end
        drive(1'b1, 4'h0, 32'h00000010, 32'h0);
        checks++;
        if (rdata !== 32'h11223344) begin
            errors++;
            $display("FAIL ram_read: got %h expected %h", rdata, 32'h11223344);
        end
    endtask

    task automatic test_byte_lanes;
        drive(1'b1, 4'b0101, 32'h00000010, 32'hAABBCCDD);
        drive(1'b1, 4'h0, 32'h00000010, 32'h0);
        checks++;
        if (rdata !== 32'h11BB33DD) begin
            errors++;
            $display("FAIL byte_lanes_0101: got %h expected %h", rdata, 32'h11BB33DD);
        end
        drive(1'b1, 4'hf, 32'h00000014, 32'h01020304);
        drive(1'b1, 4'b1010, 32'h00000014, 32'hEEFF5566);
        drive(1'b1, 4'h0, 32'h00000014, 32'h0);
        checks++;
        if (rdata !== 32'hEE025504) begin
            errors++;
            $display("FAIL byte_lanes_1010: got %h expected %h", rdata, 32'hEE025504);
        end
    endtask

    task automatic test_read_before_write;
        drive(1'b1, 4'hf, 32'h00000020, 32'hCAFEF00D);
        drive(1'b1, 4'h0, 32'h00000020, 32'h0);
        drive(1'b1, 4'hf, 32'h00000020, 32'h12345678);
        checks++;
        if (rdata !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL read_before_write: got %h expected %h", rdata, 32'hCAFEF00D);
        end
        drive(1'b1, 4'h0, 32'h00000020, 32'h0);
        checks++;
        if (rdata !== 32'h12345678) begin
            errors++;
            $display("FAIL read_after_write: got %h expected %h", rdata, 32'h12345678);
        end
    endtask

    task automatic test_led;
        drive(1'b1, 4'hf, 32'hbfaff000, 32'h0001ABCD);
        checks++;
        if (led !== 16'hABCD) begin
            errors++;
            $display("FAIL led_write: got %h expected %h", led, 16'hABCD);
        end
        drive(1'b1, 4'h0, 32'hbfaff000, 32'h0);
        checks++;
        if (rdata !== 32'h0000ABCD) begin
            errors++;
            $display("FAIL led_read: got %h expected %h", rdata, 32'h0000ABCD);
        end
        drive(1'b1, 4'b0010, 32'hbfaff000, 32'h00005500);
        checks++;
        if (led !== 16'h55CD) begin
            errors++;
            $display("FAIL led_partial: got %h expected %h", led, 16'h55CD);
        end
    endtask

    task automatic test_timer;
        logic [31:0] exp_now;
`ifdef DATA_SRAM_RESP_TIMER_EN
        exp_now = 32'hFFFFFFFE;
`else
        exp_now = 32'h0;
`endif
        drive(1'b1, 4'h0, 32'h00000010, 32'h0);
        drive(1'b1, 4'hf, 32'hbfafe000, 32'hFFFFFFFE);
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        drive(1'b1, 4'h0, 32'hbfafe000, 32'h0);
        checks++;
        if (rdata !== 32'h0) begin
            errors++;
            $display("FAIL timer_wrap: got %h expected %h", rdata, 32'h0);
        end
        drive(1'b1, 4'hf, 32'hbfafe000, 32'hFFFFFFFE);
        drive(1'b1, 4'h0, 32'hbfafe000, 32'h0);
        checks++;
        if (rdata !== exp_now) begin
            errors++;
            $display("FAIL timer_write_value: got %h expected %h", rdata, exp_now);
        end
    endtask

    task automatic test_unmapped_hold;
        drive(1'b1, 4'h0, 32'h00000010, 32'h0);
        checks++;
        if (rdata !== 32'h11BB33DD) begin
            errors++;
            $display("FAIL pre_unmapped_read: got %h expected %h", rdata, 32'h11BB33DD);
        end
        drive(1'b1, 4'hf, 32'hbfaf1234, 32'hFFFFFFFF);
        drive(1'b1, 4'h0, 32'hbfaf1234, 32'h0);
        checks++;
        if (rdata !== 32'h0) begin
            errors++;
            $display("FAIL unmapped_read: got %h expected %h", rdata, 32'h0);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 4'h0, 32'h00000010, 32'h0);
            checks++;
            if (rdata !== 32'h0) begin
                errors++;
                $display("FAIL idle_hold_%0d: got %h expected %h", i, rdata, 32'h0);
            end
        end
    endtask

    task automatic test_reset_mid_read;
        drive(1'b1, 4'hf, 32'hbfaff020, 32'h5A5A5A5A);
        drive(1'b1, 4'h0, 32'hbfaff020, 32'h0);
        checks++;
        if (rdata !== 32'h5A5A5A5A) begin
            errors++;
            $display("FAIL scratch_read: got %h expected %h", rdata, 32'h5A5A5A5A);
        end
        @(negedge clk);
        en   = 1'b1;
        we   = 4'h0;
        addr = 32'h00000010;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (rdata !== 32'h0) begin
            errors++;
            $display("FAIL async_reset_rdata: got %h expected %h", rdata, 32'h0);
        end
        checks++;
        if (led !== 16'h0) begin
            errors++;
            $display("FAIL async_reset_led: got %h expected %h", led, 16'h0);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        en    = 1'b0;
        #1;
        checks++;
        if (rdata !== 32'h0 || led !== 16'h0) begin
            errors++;
            $display("FAIL post_reset_state: got rdata %h led %h expected 0 and 0", rdata, led);
        end
        drive(1'b1, 4'h0, 32'hbfaff020, 32'h0);
        checks++;
        if (rdata !== 32'h0) begin
            errors++;
            $display("FAIL scratch_after_reset: got %h expected %h", rdata, 32'h0);
        end
        drive(1'b1, 4'h0, 32'h00000010, 32'h0);
        checks++;
        if (rdata !== 32'h11BB33DD) begin
            errors++;
            $display("FAIL ram_survives_reset: got %h expected %h", rdata, 32'h11BB33DD);
        end
        drive(1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        en     = 1'b0;
        we     = 4'h0;
        addr   = 32'h0;
        wdata  = 32'h0;
        test_reset;
        test_ram_write_read;
        test_byte_lanes;
        test_read_before_write;
        test_led;
        test_timer;
        test_unmapped_hold;
        test_reset_mid_read;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
